// File: rtl/div_pkg.sv
// Shared types and sizing for the iterative divider controller.
package div_pkg;
   localparam int DIV_WIDTH = 32;
   localparam int DIV_STEPS = 32;
   localparam int CNT_W     = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_e;
endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step on magnitudes: shift in the next dividend bit, subtract if it fits.
module div_step
   import div_pkg::*;
(
   input  logic [DIV_WIDTH-1:0] rem_i,
   input  logic [DIV_WIDTH-1:0] quo_i,
   input  logic [DIV_WIDTH-1:0] den_i,
   output logic [DIV_WIDTH-1:0] rem_o,
   output logic [DIV_WIDTH-1:0] quo_o
);
   logic [DIV_WIDTH:0] shifted;
   logic [DIV_WIDTH:0] diff;
   logic               fits;
   logic               unused_msb;

   // Remainder stays below the divisor, so a successful difference always fits in DIV_WIDTH bits.
   assign shifted    = {rem_i, quo_i[DIV_WIDTH-1]};
   assign diff       = shifted - {1'b0, den_i};
   assign fits       = shifted >= {1'b0, den_i};
   assign unused_msb = diff[DIV_WIDTH];

   always_comb begin
      rem_o = shifted[DIV_WIDTH-1:0];
      quo_o = {quo_i[DIV_WIDTH-2:0], 1'b0};
      if (fits) begin
         rem_o = diff[DIV_WIDTH-1:0];
         quo_o = {quo_i[DIV_WIDTH-2:0], 1'b1};
      end
   end
endmodule

// File: rtl/div_ctrl.sv
// Iterative 32-bit div/divu unit with pipeline stall handshake.
// Optional DIV_ZERO_FAST_EN: short-circuits a zero divisor and exposes divzero_o.
module div_ctrl
   import div_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic                 signed_i,
   input  logic [DIV_WIDTH-1:0] opa_i,
   input  logic [DIV_WIDTH-1:0] opb_i,
   input  logic                 annul_i,
   output logic                 stall_o,
   output logic                 busy_o,
   output logic                 valid_o,
   output logic [DIV_WIDTH-1:0] hi_o,
   output logic [DIV_WIDTH-1:0] lo_o
`ifdef DIV_ZERO_FAST_EN
   ,
   output logic                 divzero_o
`endif
);
   // state | meaning
   // IDLE  | no divide pending, start_i accepted
   // RUN   | one shift-subtract step per cycle, 32 steps
   // DONE  | result on hi_o/lo_o, valid_o pulse, start_i accepted

   div_state_e           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, den_q, den_d;
   logic [DIV_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic                 negq_q, negq_d, negr_q, negr_d, dz_q, dz_d;
   logic [DIV_WIDTH-1:0] rem_n, quo_n, opa_abs, opb_abs;
   logic                 accept;

   div_step u_step (
      .rem_i (rem_q),
      .quo_i (quo_q),
      .den_i (den_q),
      .rem_o (rem_n),
      .quo_o (quo_n)
   );

   assign opa_abs = (signed_i && opa_i[DIV_WIDTH-1]) ? -opa_i : opa_i;
   assign opb_abs = (signed_i && opb_i[DIV_WIDTH-1]) ? -opb_i : opb_i;
   assign accept  = start_i && !annul_i && (state_q == IDLE || state_q == DONE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      den_d   = den_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      dz_d    = dz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (accept) begin
               state_d = RUN;
               cnt_d   = '0;
               rem_d   = '0;
               quo_d   = opa_abs;
               den_d   = opb_abs;
               negq_d  = signed_i && (opa_i[DIV_WIDTH-1] ^ opb_i[DIV_WIDTH-1]);
               negr_d  = signed_i && opa_i[DIV_WIDTH-1];
               dz_d    = (opb_i == '0);
`ifdef DIV_ZERO_FAST_EN
               if (opb_i == '0) begin
                  state_d = DONE;
                  hi_d    = opa_i;
                  lo_d    = '1;
               end
`endif
            end
         end
         RUN: begin
            if (annul_i) begin
               state_d = IDLE;
            end else begin
               rem_d = rem_n;
               quo_d = quo_n;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(DIV_STEPS - 1)) begin
                  // Zero divisor leaves |opa| as remainder; the quotient is forced to all ones.
                  state_d = DONE;
                  hi_d    = negr_q ? -rem_n : rem_n;
                  lo_d    = dz_q ? '1 : (negq_q ? -quo_n : quo_n);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         den_q   <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         den_q   <= den_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         dz_q    <= dz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy_o  = (state_q == RUN);
   assign valid_o = (state_q == DONE);
   assign stall_o = busy_o || accept;
   assign hi_o    = hi_q;
   assign lo_o    = lo_q;
`ifdef DIV_ZERO_FAST_EN
   assign divzero_o = valid_o && dz_q;
`endif
endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port start_i, input, 1: execute-stage divide issue, qualified by IDLE or DONE state.
REQ-004 SHALL have port signed_i, input, 1: 1 = signed divide (div), 0 = unsigned (divu); sampled with start_i.
REQ-005 SHALL have port opa_i, input, 32: dividend; sampled with start_i.
REQ-006 SHALL have port opb_i, input, 32: divisor; sampled with start_i.
REQ-007 SHALL have port annul_i, input, 1: flush/exception cancel of the in-flight divide.
REQ-008 SHALL have port stall_o, output, 1: freeze request to the pipeline while a divide is pending.
REQ-009 SHALL have port busy_o, output, 1: high in RUN state.
REQ-010 SHALL have port valid_o, output, 1: one-cycle result pulse; hi/lo write-enable.
REQ-011 SHALL have port hi_o, output, 32: remainder.
REQ-012 SHALL have port lo_o, output, 32: quotient.
REQ-013 SHALL have port divzero_o, output, 1: divide-by-zero flag; present only with DIV_ZERO_FAST_EN.

Function
REQ-014 SHALL implement states IDLE, RUN and DONE.
REQ-015 SHALL transition IDLE->RUN and DONE->RUN on start_i=1 with annul_i=0, latching |opa|, |opb|, result signs and clearing a 6-bit step counter.
REQ-016 SHALL perform one restoring shift-subtract step per RUN cycle; RUN->DONE after step 32 completes.
REQ-017 SHALL pulse valid_o high for exactly the single DONE cycle; a start accepted at edge t SHALL give valid_o=1 in cycle t+33.
REQ-018 SHALL drive stall_o combinationally high whenever start_i=1 with annul_i=0 in IDLE/DONE, and throughout RUN; stall_o SHALL be low in DONE unless a new start is accepted.
REQ-019 SHALL hold hi_o/lo_o stable from DONE until the next DONE.
REQ-020 SHALL negate the quotient when operand signs differ (signed mode only) and give the remainder the dividend's sign.
REQ-021 SHALL return 0x80000000 / 0xFFFFFFFF signed -> lo=0x80000000, hi=0 with no error.
REQ-022 SHALL ignore start_i while in RUN.
REQ-023 SHALL on annul_i=1 in RUN return to IDLE next edge with no valid_o pulse and hi_o/lo_o unchanged.
REQ-024 SHALL ignore start_i when annul_i=1 in the same cycle.

Reset
REQ-025 SHALL with rst=1 at an edge, in any state including mid-RUN, enter IDLE and set counter=0, stall_o=0, busy_o=0, valid_o=0, hi_o=0, lo_o=0, divzero_o=0.

Configuration
REQ-026 SHALL with DIV_ZERO_FAST_EN defined detect opb_i=0 at start, go directly to DONE next edge (valid_o at t+1), assert divzero_o with valid_o, and produce hi_o=opa_i, lo_o=0xFFFFFFFF.
REQ-027 SHALL with DIV_ZERO_FAST_EN undefined omit divzero_o, run the full 33-cycle sequence for a zero divisor, and produce hi_o=opa_i, lo_o=0xFFFFFFFF irrespective of signed_i.

Structure
REQ-028 SHALL take from a shared package div_pkg the state enum (IDLE/RUN/DONE), the DIV_WIDTH=32 and DIV_STEPS=32 constants, and the width of the step counter.
REQ-029 SHALL instantiate one sub-module, div_step, containing the combinational single shift-subtract step; the FSM, sign fix-up and stall logic stay in div_ctrl.

Verification
REQ-030 SHALL cover: unsigned 100/7 started at t -> valid_o at t+33, lo_o=14, hi_o=2, stall_o high t..t+32.
REQ-031 SHALL cover: signed -7/2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; unsigned 0xFFFFFFF9/2 -> lo_o=0x7FFFFFFC, hi_o=1.
REQ-032 SHALL cover: signed 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
REQ-033 SHALL cover: annul_i at t+10 -> IDLE at t+11, stall_o low at t+11, no valid_o, hi/lo unchanged; a second start_i during RUN is ignored.
REQ-034 SHALL cover: 5/0 in both builds -> hi_o=5, lo_o=0xFFFFFFFF; valid_o at t+1 with divzero_o=1 (macro) or at t+33 (no macro).
REQ-035 SHALL cover: rst at t+20 -> IDLE and all outputs zero next cycle; back-to-back start in DONE -> new RUN with no idle gap.
